main_mem_ctrl: RTL and testbench
================================

MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter BLOCK_WORDS, default 4, words per cache block (power of 2).
REQ-003 Parameter MEM_DEPTH, default 1024, backing store depth in words (power of 2).
REQ-004 Parameter RD_LATENCY, default 4, wait cycles before read burst (>=1).
REQ-005 Parameter WR_LATENCY, default 2, wait cycles before word write (>=1).
REQ-006 clk  input  1  clock, all state updates on rising edge.
REQ-007 reset_n  input  1  reset, asynchronous, active-low.
REQ-008 mem_read_en  input  1  block refill request, level, held until ready_to_read seen.
REQ-009 mem_write_en  input  1  single-word write-through request, level, held until finished_writing seen.
REQ-010 addr  input  32  byte address of request.
REQ-011 wr_data  input  DATA_W  write-through data.
REQ-012 rd_block  output  BLOCK_WORDS*DATA_W  refilled block, word 0 in LSBs.
REQ-013 ready_to_read  output  1  rd_block valid, read complete.
REQ-014 finished_writing  output  1  write committed to backing store.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, RD_WAIT, RD_BURST, RD_DONE, WR_WAIT, WR_DONE.
REQ-017 IDLE: mem_write_en high -> WR_WAIT; else mem_read_en high -> RD_WAIT; write SHALL win when both high.
REQ-018 On accept SHALL latch addr (read: block-aligned, low log2(BLOCK_WORDS)+2 bits zeroed) and wr_data; later input changes ignored.
REQ-019 Word index SHALL be addr[log2(MEM_DEPTH)+1:2]; upper bits ignored (wrap modulo MEM_DEPTH).
REQ-020 RD_WAIT SHALL last exactly RD_LATENCY cycles, then RD_BURST.
REQ-021 RD_BURST SHALL read one word per cycle into rd_block slot 0..BLOCK_WORDS-1 in order, then RD_DONE.
REQ-022 ready_to_read SHALL be 1 only in RD_DONE; first assertion RD_LATENCY+BLOCK_WORDS+1 rising edges after the accepting edge.
REQ-023 WR_WAIT SHALL last WR_LATENCY cycles; the array write SHALL occur on its final edge, then WR_DONE.
REQ-024 finished_writing SHALL be 1 only in WR_DONE.
REQ-025 RD_DONE/WR_DONE SHALL hold until the respective enable is low, then return to IDLE (four-phase handshake; no retrigger on a stale enable).
REQ-026 Enable deasserted mid-operation SHALL NOT abort; operation completes, DONE state exits on the next edge.
REQ-027 rd_block SHALL hold its value until the next read burst overwrites it.
REQ-028 Latency counter width SHALL cover max(RD_LATENCY, WR_LATENCY, BLOCK_WORDS); no wrap beyond terminal count.
REQ-029 A write followed by a refill of the same block SHALL return the new data.

Reset
REQ-030 reset_n low SHALL force IDLE, counters 0, rd_block 0, ready_to_read 0, finished_writing 0, busy 0, immediately and at any state, aborting in-flight operations.
REQ-031 Array contents SHALL NOT be reset; an aborted write SHALL leave the target word unmodified.

Structure
REQ-032 Shared package mem_pkg SHALL hold state encoding and default parameter constants.
REQ-033 Backing store SHALL be sub-module mem_array (single-port, synchronous write, combinational read, MEM_DEPTH x DATA_W).

Verification
REQ-034 Preload words 0x40..0x4C = A0,A1,A2,A3; read addr 0x44 -> ready_to_read after 9 edges, rd_block = {A3,A2,A1,A0}.
REQ-035 Write 0xDEADBEEF to 0x48 -> finished_writing after 3 edges; then read 0x40 -> slot 2 = 0xDEADBEEF.
REQ-036 mem_read_en and mem_write_en high together in IDLE -> WR_WAIT entered, no read performed.
REQ-037 Hold mem_read_en high 3 cycles past ready_to_read -> stays RD_DONE, returns IDLE one edge after drop, no second burst.
REQ-038 reset_n low during RD_BURST and during WR_WAIT -> all outputs 0 same cycle, state IDLE, target word unchanged.
REQ-039 addr 0x0000_1004 with MEM_DEPTH 1024 -> accesses word index 1 (wrap).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the main memory controller.
package mem_pkg;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_BLOCK_WORDS = 4;
  localparam int unsigned DEF_MEM_DEPTH   = 1024;
  localparam int unsigned DEF_RD_LATENCY  = 4;
  localparam int unsigned DEF_WR_LATENCY  = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_BURST = 3'd2,
    RD_DONE  = 3'd3,
    WR_WAIT  = 3'd4,
    WR_DONE  = 3'd5
  } state_t;

  // Counter width able to hold the largest of the three terminal counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port backing store: synchronous write, combinational read, not reset.
module mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

  assign rd_data_c = mem[addr];

endmodule

// File: rtl/main_mem_ctrl.sv
// Main memory controller: block refill after a read latency, single-word write-through
// after a write latency, four-phase handshake on both request paths.
module main_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int unsigned RD_LATENCY  = DEF_RD_LATENCY,
  parameter int unsigned WR_LATENCY  = DEF_WR_LATENCY
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          mem_read_en,
  input  logic                          mem_write_en,
  input  logic [31:0]                   addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [BLOCK_WORDS*DATA_W-1:0] rd_block,
  output logic                          ready_to_read,
  output logic                          finished_writing,
  output logic                          busy
);

  localparam int unsigned AW    = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = cnt_width(RD_LATENCY, WR_LATENCY, BLOCK_WORDS);

  state_t                          state, state_next;
  logic [CNT_W-1:0]                cnt, cnt_next;
  logic [AW-1:0]                   idx_q, idx_next;
  logic [DATA_W-1:0]               data_q, data_next;
  logic [BLOCK_WORDS*DATA_W-1:0]   rd_block_next;
  logic                            ready_next, finished_next, busy_next;
  logic [AW-1:0]                   mem_addr_c;
  logic                            mem_we_c;
  logic [DATA_W-1:0]               mem_rd_c;
  logic                            unused_addr_c;

  // Upper address bits wrap away; byte offset is irrelevant for word accesses.
  assign unused_addr_c = ^{addr[31:AW+2], addr[1:0]};

  // Burst walks the aligned block; writes use the latched word index directly.
  assign mem_addr_c = (state == RD_BURST) ? (idx_q | AW'(cnt)) : idx_q;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk       (clk),
    .we        (mem_we_c),
    .addr      (mem_addr_c),
    .wr_data   (data_q),
    .rd_data_c (mem_rd_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      cnt              <= '0;
      idx_q            <= '0;
      data_q           <= '0;
      rd_block         <= '0;
      ready_to_read    <= 1'b0;
      finished_writing <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      idx_q            <= idx_next;
      data_q           <= data_next;
      rd_block         <= rd_block_next;
      ready_to_read    <= ready_next;
      finished_writing <= finished_next;
      busy             <= busy_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    idx_next      = idx_q;
    data_next     = data_q;
    rd_block_next = rd_block;
    mem_we_c      = 1'b0;

    case (state)
      IDLE: begin
        // Write wins when both requests arrive together.
        if (mem_write_en) begin
          state_next = WR_WAIT;
          cnt_next   = '0;
          idx_next   = addr[AW+1:2];
          data_next  = wr_data;
        end else if (mem_read_en) begin
          state_next = RD_WAIT;
          cnt_next   = '0;
          idx_next   = addr[AW+1:2] & ~AW'(BLOCK_WORDS - 1);
        end
      end
      RD_WAIT: begin
        if (cnt == CNT_W'(RD_LATENCY - 1)) begin
          state_next = RD_BURST;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RD_BURST: begin
        rd_block_next[int'(cnt)*DATA_W +: DATA_W] = mem_rd_c;
        if (cnt == CNT_W'(BLOCK_WORDS - 1)) begin
          state_next = RD_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RD_DONE: begin
        if (!mem_read_en) state_next = IDLE;
      end
      WR_WAIT: begin
        if (cnt == CNT_W'(WR_LATENCY - 1)) begin
          mem_we_c   = 1'b1;
          state_next = WR_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      WR_DONE: begin
        if (!mem_write_en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    ready_next    = (state_next == RD_DONE);
    finished_next = (state_next == WR_DONE);
    busy_next     = (state_next != IDLE);
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: vector table with a model scoreboard,
// plus hand sequences for handshake, priority and reset-abort corners.
module tb_main_mem_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int BUDGET = 40;

  typedef logic [BW*DW-1:0] blk_t;
  typedef struct {
    bit          is_wr;
    logic [31:0] a;
    logic [31:0] d;
    int          lat;
    bit          drop;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [31:0]   addr;
  logic [DW-1:0] wr_data;
  blk_t          rd_block;
  logic          ready_to_read;
  logic          finished_writing;
  logic          busy;

  int   checks = 0;
  int   errors = 0;
  logic [31:0] model_mem [1024];
  blk_t exp_q [$];
  blk_t last_rd_exp;
  vec_t vt [13];

  main_mem_ctrl u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_read_en      (mem_read_en),
    .mem_write_en     (mem_write_en),
    .addr             (addr),
    .wr_data          (wr_data),
    .rd_block         (rd_block),
    .ready_to_read    (ready_to_read),
    .finished_writing (finished_writing),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  function automatic blk_t model_block(input logic [31:0] a);
    blk_t b;
    logic [9:0] base;
    base = a[11:2] & 10'h3FC;
    for (int i = 0; i < BW; i++) b[i*DW +: DW] = model_mem[base + 10'(i)];
    return b;
  endfunction

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_blk(input string name, input blk_t got, input blk_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One request with bounded wait; counts edges from the accepting edge inclusive.
  task automatic run_txn(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                         input int exp_lat, input bit drop, input string name);
    int   edges;
    logic seen;
    blk_t eb;
    @(negedge clk);
    addr    = a;
    wr_data = d;
    if (is_wr) begin
      mem_write_en = 1'b1;
      model_mem[a[11:2]] = d;
    end else begin
      mem_read_en = 1'b1;
      exp_q.push_back(model_block(a));
    end
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    addr    = $urandom;
    wr_data = $urandom;
    if (drop) begin
      mem_write_en = 1'b0;
      mem_read_en  = 1'b0;
    end
    seen = is_wr ? finished_writing : ready_to_read;
    while (!seen && edges < BUDGET) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      seen = is_wr ? finished_writing : ready_to_read;
    end
    check_int({name, " latency"}, seen ? edges : -1, exp_lat);
    if (!is_wr && exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      last_rd_exp = eb;
      check_blk({name, " block"}, rd_block, eb);
    end
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_int({name, " idle"}, int'({busy, ready_to_read, finished_writing}), 0);
  endtask

  initial begin
    int   edges;
    logic seen;
    logic bad;
    blk_t eb;

    reset_n      = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    addr         = '0;
    wr_data      = '0;

    vt[0]  = '{1'b1, 32'h0000_0040, 32'h0000_00A0, 3, 1'b0};
    vt[1]  = '{1'b1, 32'h0000_0044, 32'h0000_00A1, 3, 1'b0};
    vt[2]  = '{1'b1, 32'h0000_0048, 32'h0000_00A2, 3, 1'b0};
    vt[3]  = '{1'b1, 32'h0000_004C, 32'h0000_00A3, 3, 1'b0};
    vt[4]  = '{1'b0, 32'h0000_0044, 32'h0,         9, 1'b0};
    vt[5]  = '{1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 3, 1'b0};
    vt[6]  = '{1'b0, 32'h0000_0040, 32'h0,         9, 1'b0};
    vt[7]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 3, 1'b0};
    vt[8]  = '{1'b1, 32'h0000_0004, 32'h2222_2222, 3, 1'b1};
    vt[9]  = '{1'b1, 32'h0000_0008, 32'h3333_3333, 3, 1'b0};
    vt[10] = '{1'b1, 32'h0000_000C, 32'h4444_4444, 3, 1'b0};
    vt[11] = '{1'b0, 32'h0000_1004, 32'h0,         9, 1'b0};
    vt[12] = '{1'b0, 32'h0000_2048, 32'h0,         9, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_int("reset flags", int'({busy, ready_to_read, finished_writing}), 0);
    check_blk("reset rd_block", rd_block, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_int("post-reset idle", int'(busy), 0);

    for (int i = 0; i < 13; i++)
      run_txn(vt[i].is_wr, vt[i].a, vt[i].d, vt[i].lat, vt[i].drop, $sformatf("vec%0d", i));

    // Both requests in IDLE: only the write happens.
    @(negedge clk);
    addr = 32'h0000_004C;
    wr_data = 32'h5555_AAAA;
    mem_write_en = 1'b1;
    mem_read_en  = 1'b1;
    model_mem[10'h013] = 32'h5555_AAAA;
    edges = 0; seen = 1'b0; bad = 1'b0;
    while (!seen && edges < BUDGET) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      seen = finished_writing;
      if (ready_to_read) bad = 1'b1;
    end
    check_int("both latency", seen ? edges : -1, 3);
    check_int("both no read", int'(bad), 0);
    check_blk("both rd_block held", rd_block, last_rd_exp);
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_int("both idle", int'(busy), 0);
    run_txn(1'b0, 32'h0000_0040, 32'h0, 9, 1'b0, "after both");

    // Read enable held past completion: stays done, single burst.
    @(negedge clk);
    addr = 32'h0000_0000;
    mem_read_en = 1'b1;
    exp_q.push_back(model_block(32'h0));
    edges = 0; seen = 1'b0;
    while (!seen && edges < BUDGET) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      seen = ready_to_read;
    end
    check_int("hold latency", seen ? edges : -1, 9);
    eb = exp_q.pop_front();
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!ready_to_read || !busy) bad = 1'b1;
    end
    check_int("hold stays done", int'(bad), 0);
    check_blk("hold block", rd_block, eb);
    mem_read_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_int("hold exit", int'({busy, ready_to_read}), 0);
    bad = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (busy || ready_to_read) bad = 1'b1;
    end
    check_int("hold no retrigger", int'(bad), 0);

    // Reset during the burst clears everything at once.
    @(negedge clk);
    addr = 32'h0000_0040;
    mem_read_en = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    mem_read_en = 1'b0;
    #1;
    check_int("rst burst flags", int'({busy, ready_to_read, finished_writing}), 0);
    check_blk("rst burst rd_block", rd_block, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_int("rst burst idle", int'(busy), 0);

    // Reset during the write wait leaves the target word untouched.
    @(negedge clk);
    addr = 32'h0000_0048;
    wr_data = 32'h1234_5678;
    mem_write_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_int("rst wr busy", int'(busy), 1);
    reset_n = 1'b0;
    mem_write_en = 1'b0;
    #1;
    check_int("rst wr flags", int'({busy, ready_to_read, finished_writing}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_txn(1'b0, 32'h0000_0040, 32'h0, 9, 1'b0, "rst wr readback");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
